sp_memory_arbiter: RTL and testbench

- Two-requester arbiter that shares one sp_memory core (1-cycle synchronous read) between two masters, e.g. a DMA engine and an APB or CPU port.
- Uses a req/gnt handshake with a single-cycle command transfer.
- Returns read data to the winning requester one cycle after its grant.
- A bounded-hold round-robin scheme gives each side burst locality without starving the other.

---
 rtl/sp_memory_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_sp_memory_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sp_memory_arbiter.sv
// Two-requester arbiter sharing one single-port memory (1-cycle read latency).
// Bounded-hold round-robin: the last winner keeps the port for up to MAX_HOLD grants under contention.
module sp_memory_arbiter #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 1024,
  parameter  int MAX_HOLD = 4,
  localparam int AW       = $clog2(DEPTH),
  localparam int SW       = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [AW-1:0]    m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  input  logic [SW-1:0]    m0_wstrb,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [WIDTH-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [AW-1:0]    m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  input  logic [SW-1:0]    m1_wstrb,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] m1_rdata,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [SW-1:0]    mem_wstrb,
  input  logic [WIDTH-1:0] mem_rdata
);

  // Counter just wide enough to hold MAX_HOLD so saturation is the only way to stop it.
  localparam int            CW       = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  logic          last_r;
  logic [CW-1:0] run_cnt_r;
  logic          rd_pend_r;
  logic          rd_src_r;

  logic          gnt0_s;
  logic          gnt1_s;
  logic          sel_s;
  logic          any_gnt_s;
  logic          last_nxt_s;
  logic [CW-1:0] run_cnt_nxt_s;

  // Grant decision: single requester always wins; on a tie the hold counter picks.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    sel_s  = last_r;
    case ({m1_req, m0_req})
      2'b01: gnt0_s = 1'b1;
      2'b10: gnt1_s = 1'b1;
      2'b11: begin
        if (run_cnt_r < HOLD_MAX) begin
          sel_s = last_r;
        end else begin
          sel_s = ~last_r;
        end
        gnt0_s = ~sel_s;
        gnt1_s = sel_s;
      end
      default: begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    endcase
  end

  assign any_gnt_s = gnt0_s | gnt1_s;
  assign m0_gnt    = gnt0_s;
  assign m1_gnt    = gnt1_s;

  // Next hold state: repeat winner counts up (saturating), a new winner restarts at 1, idle clears.
  always_comb begin
    last_nxt_s    = last_r;
    run_cnt_nxt_s = '0;
    if (any_gnt_s) begin
      if (gnt1_s == last_r) begin
        if (run_cnt_r == HOLD_MAX) begin
          run_cnt_nxt_s = run_cnt_r;
        end else begin
          run_cnt_nxt_s = run_cnt_r + CW'(1);
        end
      end else begin
        last_nxt_s    = gnt1_s;
        run_cnt_nxt_s = CW'(1);
      end
    end else begin
      run_cnt_nxt_s = '0;
    end
  end

  // Arbitration state and read-return tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r    <= 1'b0;
      run_cnt_r <= '0;
      rd_pend_r <= 1'b0;
      rd_src_r  <= 1'b0;
    end else begin
      last_r    <= last_nxt_s;
      run_cnt_r <= run_cnt_nxt_s;
      rd_pend_r <= any_gnt_s & ~mem_we;
      rd_src_r  <= gnt1_s;
    end
  end

  // Memory command mux; everything is zero when nothing is granted.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case ({gnt1_s, gnt0_s})
      2'b01: begin
        mem_we    = m0_we;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wstrb = m0_wstrb;
      end
      2'b10: begin
        mem_we    = m1_we;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_wstrb = m1_wstrb;
      end
      default: begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
      end
    endcase
  end

  assign mem_cs    = any_gnt_s;
  assign m0_rvalid = rd_pend_r & ~rd_src_r;
  assign m1_rvalid = rd_pend_r &  rd_src_r;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

  sp_memory_arbiter_chk #(
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) u_chk (
    .clk    (clk),
    .rst    (rst),
    .m0_req (m0_req),
    .m1_req (m1_req),
    .m0_gnt (gnt0_s),
    .m1_gnt (gnt1_s)
  );

endmodule

// Protocol and parameter checks for the arbiter.
module sp_memory_arbiter_chk #(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 4
) (
  input logic clk,
  input logic rst,
  input logic m0_req,
  input logic m1_req,
  input logic m0_gnt,
  input logic m1_gnt
);

  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("sp_memory_arbiter: MAX_HOLD must be at least 1");
  end

  if ((WIDTH % 8) != 0) begin : g_bad_width
    $error("sp_memory_arbiter: WIDTH must be a multiple of 8");
  end

  a_one_hot_gnt : assert property (@(posedge clk) disable iff (rst) !(m0_gnt && m1_gnt));
  a_gnt0_has_req : assert property (@(posedge clk) disable iff (rst) m0_gnt |-> m0_req);
  a_gnt1_has_req : assert property (@(posedge clk) disable iff (rst) m1_gnt |-> m1_req);

endmodule

// File: tb/tb_sp_memory_arbiter.sv
// Directed bench for sp_memory_arbiter with a behavioural 1-cycle memory model.
module tb_sp_memory_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int SW    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0]    m0_addr, m1_addr;
  logic [WIDTH-1:0] m0_wdata, m1_wdata;
  logic [SW-1:0]    m0_wstrb, m1_wstrb;
  logic             m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [WIDTH-1:0] m0_rdata, m1_rdata;
  logic             mem_cs, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;
  logic [SW-1:0]    mem_wstrb;

  // Second instance for strict alternation (MAX_HOLD = 1).
  logic             a_req0, a_req1;
  logic             a_gnt0, a_gnt1, a_rv0, a_rv1, a_cs, a_we;
  logic [WIDTH-1:0] a_rd0, a_rd1, a_wdata;
  logic [AW-1:0]    a_addr;
  logic [SW-1:0]    a_wstrb;

  logic [WIDTH-1:0] mem_model [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  sp_memory_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  sp_memory_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_HOLD(1)) dut_alt (
    .clk(clk), .rst(rst),
    .m0_req(a_req0), .m0_we(1'b0), .m0_addr(10'd1), .m0_wdata(32'd0), .m0_wstrb(4'd0),
    .m0_gnt(a_gnt0), .m0_rvalid(a_rv0), .m0_rdata(a_rd0),
    .m1_req(a_req1), .m1_we(1'b0), .m1_addr(10'd2), .m1_wdata(32'd0), .m1_wstrb(4'd0),
    .m1_gnt(a_gnt1), .m1_rvalid(a_rv1), .m1_rdata(a_rd1),
    .mem_cs(a_cs), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .mem_wstrb(a_wstrb), .mem_rdata(32'd0)
  );

  // Memory model: byte-masked write, registered read.
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) begin
        for (int b = 0; b < SW; b++)
          if (mem_wstrb[b]) mem_model[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem_model[mem_addr];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    a_req0 = 1'b0; a_req1 = 1'b0;
  endtask

  logic [31:0] hold_seq;
  int          prev_win;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'h0;
    mem_model[16] = 32'hDEADBEEF;
    mem_model[5]  = 32'hFFFFFFFF;
    mem_rdata = 32'h0;
    idle_all();
    rst = 1'b1;

    // Reset state
    step();
    @(negedge clk);
    check_eq("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    check_eq("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    check_eq("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    check_eq("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
    step();
    rst = 1'b0;

    // Single read by m0
    m0_req = 1'b1; m0_addr = 10'h010;
    @(negedge clk);
    check_eq("rd_m0_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    check_eq("rd_mem_addr", {22'd0, mem_addr}, 32'h10);
    check_eq("rd_mem_we", {31'd0, mem_we}, 32'd0);
    step();
    m0_req = 1'b0;
    @(negedge clk);
    check_eq("rd_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    check_eq("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check_eq("rd_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    check_eq("rd_idle_cs", {31'd0, mem_cs}, 32'd0);

    // m1 partial write then read of the same word
    step();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 10'd5; m1_wdata = 32'h12345678; m1_wstrb = 4'b0011;
    @(negedge clk);
    check_eq("wr_m1_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
    check_eq("wr_mem_we", {31'd0, mem_we}, 32'd1);
    check_eq("wr_mem_wstrb", {28'd0, mem_wstrb}, 32'h3);
    check_eq("wr_mem_wdata", mem_wdata, 32'h12345678);
    step();
    m1_we = 1'b0; m1_wdata = '0; m1_wstrb = '0;
    @(negedge clk);
    check_eq("wr_no_resp", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    check_eq("rd5_m1_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
    step();
    m1_req = 1'b0;
    @(negedge clk);
    check_eq("rd5_m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
    check_eq("rd5_m1_rdata", m1_rdata, 32'hFFFF5678);
    check_eq("rd5_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);

    // Fresh reset, then continuous contention on both instances
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m0_req = 1'b1; m0_addr = 10'h010;
    m1_req = 1'b1; m1_addr = 10'd5;
    a_req0 = 1'b1; a_req1 = 1'b1;
    hold_seq = 32'b0011110000;  // bit i = winner of grant i (1 = m1)
    prev_win = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq($sformatf("hold_gnt%0d", i), {30'd0, m1_gnt, m0_gnt}, hold_seq[i] ? 32'd2 : 32'd1);
      check_eq($sformatf("alt_gnt%0d", i), {30'd0, a_gnt1, a_gnt0}, (i % 2 == 1) ? 32'd2 : 32'd1);
      if (prev_win >= 0)
        check_eq($sformatf("hold_rv%0d", i), {30'd0, m1_rvalid, m0_rvalid}, (prev_win == 1) ? 32'd2 : 32'd1);
      prev_win = hold_seq[i] ? 1 : 0;
      step();
    end
    idle_all();
    @(negedge clk);
    check_eq("hold_last_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd1);
    check_eq("hold_last_data", m0_rdata, 32'hDEADBEEF);
    step();

    // Idle cycle clears the run count
    m0_req = 1'b1; m0_addr = 10'h010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("idle_m0_%0d", i), {30'd0, m1_gnt, m0_gnt}, 32'd1);
      step();
    end
    m0_req = 1'b0;
    @(negedge clk);
    check_eq("idle_gap", {31'd0, mem_cs}, 32'd0);
    step();
    m0_req = 1'b1; m1_req = 1'b1; m1_addr = 10'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("idle_tie%0d", i), {30'd0, m1_gnt, m0_gnt}, (i == 4) ? 32'd2 : 32'd1);
      step();
    end

    // Saturation: nine solo grants must leave the count at MAX_HOLD
    m1_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_eq($sformatf("sat_m0_%0d", i), {30'd0, m1_gnt, m0_gnt}, 32'd1);
      step();
    end
    m1_req = 1'b1;
    @(negedge clk);
    check_eq("sat_switch", {30'd0, m1_gnt, m0_gnt}, 32'd2);
    step();
    idle_all();
    step();

    // Reset while a read is pending
    m0_req = 1'b1; m0_addr = 10'h010;
    @(negedge clk);
    check_eq("rrd_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    step();
    m0_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rrd_rv_in_rst", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rrd_rv_after", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    step();
    m0_req = 1'b1; m1_req = 1'b1; m1_addr = 10'd5;
    @(negedge clk);
    check_eq("rrd_first_tie", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    step();
    idle_all();
    @(negedge clk);
    check_eq("rrd_tie_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
